// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, host command bytes,
// the device acknowledge code and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    SETUP     = 3'd2,
    BITS      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_CODE    = 8'hFA;

  // Index of the stop bit within a host frame; 0..7 data, 8 parity.
  localparam logic [3:0] STOP_IDX = 4'd9;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines with a falling-edge
// strobe on the clock; idle level of both lines is high.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_line_i,
  input  logic dat_line_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic fall_o
);

  logic clk_m_q, clk_s_q, clk_prev_q;
  logic dat_m_q, dat_s_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_m_q    <= 1'b1;
      clk_s_q    <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_m_q    <= 1'b1;
      dat_s_q    <= 1'b1;
    end else begin
      clk_m_q    <= clk_line_i;
      clk_s_q    <= clk_m_q;
      clk_prev_q <= clk_s_q;
      dat_m_q    <= dat_line_i;
      dat_s_q    <= dat_m_q;
    end
  end

  assign clk_s_o = clk_s_q;
  assign dat_s_o = dat_s_q;
  assign fall_o  = clk_prev_q & ~clk_s_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data enables.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte once before err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 6000,
  parameter int SETUP_CYC   = 50,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rdy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int MAX_A   = (INHIBIT_CYC > SETUP_CYC) ? INHIBIT_CYC : SETUP_CYC;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  ps2_tx_state_e    state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q;
  logic [8:0]       frame_q;
  logic             nack_q, retried_q;
  logic             clk_oe_q, dat_oe_q, tx_rdy_q, busy_q, done_q, err_q;

  logic clk_s, dat_s, fall;
  logic tx_bit_d, active_d, timeout_d, lines_idle_d, fail_d, retry_d, accept_d;

  ps2_line_sync u_sync (
    .clk_i      (clk50),
    .rst_i      (reset),
    .clk_line_i (ps2_clk_in),
    .dat_line_i (ps2_dat_in),
    .clk_s_o    (clk_s),
    .dat_s_o    (dat_s),
    .fall_o     (fall)
  );

  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    accept_d     = (state_q == IDLE) && tx_vld && tx_rdy_q;
    tx_bit_d     = (idx_q < STOP_IDX) ? frame_q[idx_q] : 1'b1;
    active_d     = (state_q == BITS) || (state_q == ACK) || (state_q == WAIT_IDLE);
    // A fall in the same cycle as expiry counts as the device still being alive.
    timeout_d    = active_d && !fall && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    lines_idle_d = clk_s && dat_s;
    fail_d       = timeout_d || ((state_q == WAIT_IDLE) && lines_idle_d && nack_q);
    retry_d      = RETRY_EN && fail_d && !retried_q;
  end

  // Frame payload is pure data and only meaningful after an accept.
  always_ff @(posedge clk50) begin
    if (accept_d) frame_q <= {odd_parity(tx_data), tx_data};
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      nack_q    <= 1'b0;
      retried_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      tx_rdy_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= cnt_d;
      if (retry_d) begin
        retried_q <= 1'b1;
        state_q   <= INHIBIT;
        cnt_q     <= '0;
        clk_oe_q  <= 1'b1;
        dat_oe_q  <= 1'b0;
      end else if (fail_d) begin
        state_q  <= IDLE;
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        tx_rdy_q <= 1'b1;
        busy_q   <= 1'b0;
        err_q    <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (accept_d) begin
              state_q   <= INHIBIT;
              clk_oe_q  <= 1'b1;
              tx_rdy_q  <= 1'b0;
              busy_q    <= 1'b1;
              retried_q <= 1'b0;
            end
          end
          INHIBIT: begin
            if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
              state_q  <= SETUP;
              dat_oe_q <= 1'b1;
              cnt_q    <= '0;
            end
          end
          SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
              state_q  <= BITS;
              clk_oe_q <= 1'b0;
              cnt_q    <= '0;
              idx_q    <= '0;
            end
          end
          BITS: begin
            if (fall) begin
              cnt_q    <= '0;
              dat_oe_q <= ~tx_bit_d;
              idx_q    <= idx_q + 4'd1;
              if (idx_q == STOP_IDX) state_q <= ACK;
            end
          end
          ACK: begin
            dat_oe_q <= 1'b0;
            if (fall) begin
              cnt_q   <= '0;
              nack_q  <= dat_s;
              state_q <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            // NACK with idle lines is handled as a failure above.
            if (lines_idle_d) begin
              state_q  <= IDLE;
              tx_rdy_q <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_rdy     = tx_rdy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
